// File: rtl/mc_recon.sv
// Motion-compensated reconstruction: reference 16x16 block + signed residual stream -> saturated pixels.
// One write per accepted residual (1 cycle later); res_valid stalls hold all state. MC_SAD_CHECK_EN adds res_sad.
module mc_recon #(
    parameter int WIDTH    = 352,
    parameter int HEIGHT   = 240,
    parameter int MV_RANGE = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] ref_start_addr,
    input  logic [31:0] out_start_addr,
    input  logic [31:0] mb_x_pos,
    input  logic [31:0] mb_y_pos,
    input  logic [5:0]  mv_x,
    input  logic [5:0]  mv_y,
    output logic [31:0] mem_addr,
    input  logic [7:0]  mem_rdata,
    input  logic        res_valid,
    input  logic [8:0]  res_data,
    output logic        res_ready,
    output logic        wr_en,
    output logic [31:0] wr_addr,
    output logic [7:0]  wr_data,
    output logic        mv_err,
    output logic        busy,
`ifdef MC_SAD_CHECK_EN
    output logic [15:0] res_sad,
`endif
    output logic        done
);
    localparam logic [31:0] W32  = 32'(WIDTH);
    localparam int          XMAX = WIDTH - 16;
    localparam int          YMAX = HEIGHT - 16;

    typedef enum logic [2:0] {IDLE, LATCH, RUN, FLUSH, DONE} state_t;
    state_t state, state_nxt;

    logic [31:0]        ref_start_q, out_start_q, mb_x_q, mb_y_q;
    logic [5:0]         mvx_q, mvy_q;
    logic [31:0]        ref_base, out_base, pix_off;
    logic [7:0]         pixel_cnt;
    logic signed [31:0] mvx_s, mvy_s, mvx_c, mvy_c, rx_raw, ry_raw, ref_x, ref_y;
    logic               clip_x, clip_y, hs;
    logic signed [10:0] sum;
    logic [7:0]         sum_sat;

    // MV clip and reference-window clamp, evaluated from the latched inputs during LATCH
    always_comb begin
        mvx_s = {{26{mvx_q[5]}}, mvx_q};
        mvy_s = {{26{mvy_q[5]}}, mvy_q};
        mvx_c = mvx_s;
        mvy_c = mvy_s;
        if (mvx_s > MV_RANGE)       mvx_c = MV_RANGE;
        else if (mvx_s < -MV_RANGE) mvx_c = -MV_RANGE;
        if (mvy_s > MV_RANGE)       mvy_c = MV_RANGE;
        else if (mvy_s < -MV_RANGE) mvy_c = -MV_RANGE;
        clip_x = (mvx_c != mvx_s);
        clip_y = (mvy_c != mvy_s);
        rx_raw = $signed(mb_x_q) + mvx_c;
        ry_raw = $signed(mb_y_q) + mvy_c;
        ref_x  = rx_raw;
        ref_y  = ry_raw;
        if (rx_raw < 0)         ref_x = '0;
        else if (rx_raw > XMAX) ref_x = XMAX;
        if (ry_raw < 0)         ref_y = '0;
        else if (ry_raw > YMAX) ref_y = YMAX;
    end

    assign pix_off = 32'(pixel_cnt[7:4]) * W32 + 32'(pixel_cnt[3:0]);
    assign hs      = (state == RUN) && res_valid;
    assign sum     = $signed({3'b000, mem_rdata}) + $signed({{2{res_data[8]}}, res_data});
    assign sum_sat = sum[10] ? 8'd0 : ((sum > 11'sd255) ? 8'hFF : sum[7:0]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = (state != IDLE);
        done      = (state == DONE);
        res_ready = (state == RUN);
        mem_addr  = '0;
        case (state)
            IDLE:    if (start) state_nxt = LATCH;
            LATCH:   state_nxt = RUN;
            RUN: begin
                mem_addr = ref_base + pix_off;
                if (res_valid && pixel_cnt == 8'hFF) state_nxt = FLUSH;
            end
            FLUSH:   state_nxt = DONE;
            DONE:    if (!start) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ref_start_q <= '0;
            out_start_q <= '0;
            mb_x_q      <= '0;
            mb_y_q      <= '0;
            mvx_q       <= '0;
            mvy_q       <= '0;
            ref_base    <= '0;
            out_base    <= '0;
            pixel_cnt   <= '0;
            mv_err      <= 1'b0;
            wr_en       <= 1'b0;
            wr_addr     <= '0;
            wr_data     <= '0;
        end else begin
            wr_en <= hs;
            if (state == IDLE && start) begin
                ref_start_q <= ref_start_addr;
                out_start_q <= out_start_addr;
                mb_x_q      <= mb_x_pos;
                mb_y_q      <= mb_y_pos;
                mvx_q       <= mv_x;
                mvy_q       <= mv_y;
            end
            if (state == LATCH) begin
                mv_err    <= clip_x | clip_y;
                ref_base  <= ref_start_q + $unsigned(ref_y) * W32 + $unsigned(ref_x);
                out_base  <= out_start_q + mb_y_q * W32 + mb_x_q;
                pixel_cnt <= '0;
            end
            if (hs) begin
                wr_data   <= sum_sat;
                wr_addr   <= out_base + pix_off;
                pixel_cnt <= pixel_cnt + 8'd1;
            end
        end
    end

`ifdef MC_SAD_CHECK_EN
    logic [8:0]  res_abs;
    logic [16:0] sad_sum;
    assign res_abs = res_data[8] ? (~res_data + 9'd1) : res_data;
    assign sad_sum = {1'b0, res_sad} + 17'(res_abs);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)              res_sad <= '0;
        else if (state == LATCH) res_sad <= '0;
        else if (hs)             res_sad <= sad_sum[16] ? 16'hFFFF : sad_sum[15:0];
    end
`endif
endmodule

// File: doc/mc_recon.md
Name: mc_recon

Overview:
- Motion-compensated reconstruction block; it is the decoder-side counterpart of the hexagon-based motion estimator.
- Takes one macroblock's motion vector (mv_x, mv_y in the estimator's output format) and reads the 16x16 reference block through the shared read interface.
- Adds an incoming stream of signed residuals to that block, saturates each result, and writes 256 reconstructed pixels into the output frame.
- Sits after the estimator in the encoder's reconstruction loop and in the decoder model.

Parameters:
- WIDTH, 352, frame width in pixels
- HEIGHT, 240, frame height in pixels
- MV_RANGE, 16, largest legal motion-vector magnitude in each axis

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  level request; a rising level is sampled in IDLE
- ref_start_addr  in  32  base address of the reference frame
- out_start_addr  in  32  base address of the reconstructed frame
- mb_x_pos  in  32  macroblock x position in pixels (multiple of 16)
- mb_y_pos  in  32  macroblock y position in pixels (multiple of 16)
- mv_x  in  6  signed horizontal motion vector
- mv_y  in  6  signed vertical motion vector
- mem_addr  out  32  read address, combinational
- mem_rdata  in  8  read data, valid in the same cycle as mem_addr
- res_valid  in  1  residual sample valid
- res_data  in  9  signed residual, -255..255, raster order
- res_ready  out  1  residual accepted when res_valid & res_ready
- wr_en  out  1  write strobe, registered
- wr_addr  out  32  write address, registered
- wr_data  out  8  reconstructed pixel, registered
- mv_err  out  1  the latched MV was outside ±MV_RANGE and has been clipped
- busy  out  1  high in every state except IDLE
- done  out  1  block complete

Behaviour:
- Reset values: state IDLE; pixel_cnt, wr_en, wr_addr, wr_data, mv_err, done, res_ready and mem_addr all 0.
- Async reset clears everything mid-operation. A partially written block is abandoned and nothing is replayed.
- States: IDLE -> LATCH -> RUN -> FLUSH -> DONE -> IDLE.
- IDLE:
  - done=0.
  - When start=1: latch mb_x_pos, mb_y_pos, mv_x, mv_y and both base addresses; go to LATCH.
- LATCH (1 cycle):
  - Clip each MV component to [-MV_RANGE, +MV_RANGE]. Set mv_err=1 if either component was clipped, else 0.
  - ref_x = mb_x + mvx_c, clamped to [0, WIDTH-16]; ref_y = mb_y + mvy_c, clamped to [0, HEIGHT-16]. Use 32-bit signed arithmetic.
  - pixel_cnt=0. Go to RUN.
- RUN:
  - res_ready=1.
  - mem_addr = ref_start + ref_y*WIDTH + ref_x + pixel_cnt[7:4]*WIDTH + pixel_cnt[3:0].
  - On a handshake (res_valid=1):
    - sum = mem_rdata + res_data as a signed 10-bit value, saturated to 0..255.
    - Next cycle: wr_en=1, wr_data=saturated sum, wr_addr = out_start + mb_y*WIDTH + mb_x + pixel_cnt[7:4]*WIDTH + pixel_cnt[3:0].
    - Increment pixel_cnt.
  - With res_valid=0: stall. pixel_cnt holds, wr_en=0 next cycle, mem_addr stays stable.
  - Handshake at pixel_cnt=255: go to FLUSH.
- FLUSH (1 cycle): res_ready=0. The last write (pixel 255) is presented in this cycle.
- DONE:
  - wr_en=0, done=1, res_ready=0.
  - Stay in DONE while start=1; return to IDLE when start=0. done drops on the IDLE cycle.
- Latency: first wr_en one cycle after the first handshake. With no stalls, 256 writes in 256 consecutive cycles; done is seen 259 cycles after start is sampled.
- Ignored inputs:
  - start while busy has no effect.
  - res_valid outside RUN is not consumed.
  - Input port changes after LATCH have no effect; all are latched.
- mem_addr is 0 in every state except RUN.
- mv_err holds its value until the next LATCH.

Optional Feature:
- Macro: MC_SAD_CHECK_EN.
- Defined:
  - Extra output res_sad [15:0], reset 0.
  - Cleared in LATCH; accumulates |res_data| on each handshake, saturating at 16'hFFFF.
  - Valid while done=1.
  - Used to cross-check the estimator's sad output when residual = current - reference.
- Undefined: port absent, no accumulator logic.

Test Plan:
- Zero vector, interior block: mb=(64,16), mv=(0,0), ref pixel = (x+y)&255, residual 0 streamed with no stalls -> 256 writes, wr_data equals ref at the same location, wr_addr starts at out_start+16*352+64, done exactly 259 cycles after start.
- Saturation: ref block all 250, residual +10 then -300-equivalent pattern (+10 / -255 alternating) with ref 5 on the odd pixels -> wr_data 255 and 0 respectively, never wrapping.
- Edge clamp: mb=(0,0), mv=(-8,-8) -> read addresses start at ref_start+0 (clamped). mb=(336,224), mv=(+8,+8) -> reads start at ref_start+224*352+336.
- MV clip: mv_x=+25, mv_y=-20 -> mv_err=1, effective vector (+16,-16). Next block with mv=(3,-2) -> mv_err=0.
- Stalls and reset: res_valid toggles 1,0,0,1 ... -> wr_en only after handshakes, pixel_cnt holds during stalls. rst_n=0 at pixel 100 -> all outputs 0 next edge, state IDLE, and a new start then produces a full 256-write block.
- MC_SAD_CHECK_EN: residual = +3 on 128 pixels and -5 on 128 pixels -> res_sad=1024 at done. All 256 residuals = 255 -> res_sad=65280 (no saturation).
